// File: rtl/vector_mem_sequencer.sv
// Strided vector load/store sequencer for a single-port word memory.
// One element per cycle, bounds-checked against MEM_SIZE.
module vector_mem_sequencer #(
  parameter int ADDRESS_WIDTH = 19,
  parameter int DATA_WIDTH    = 64,
  parameter int LANES         = 8,
  parameter int MEM_SIZE      = 2000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        isStore,
  input  logic [ADDRESS_WIDTH-1:0]    baseAddress,
  input  logic [ADDRESS_WIDTH-1:0]    stride,
  input  logic [3:0]                  count,
  input  logic [LANES*DATA_WIDTH-1:0] storeData,
  input  logic [DATA_WIDTH-1:0]       memReadData,
  output logic [ADDRESS_WIDTH-1:0]    memReadAddress,
  output logic [ADDRESS_WIDTH-1:0]    memWriteAddress,
  output logic [DATA_WIDTH-1:0]       memWriteData,
  output logic                        memWriteEnable,
  output logic [LANES*DATA_WIDTH-1:0] loadData,
  output logic                        busy,
  output logic                        done,
  output logic                        error
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [ADDRESS_WIDTH:0] MEM_LIMIT =
    (ADDRESS_WIDTH+1)'(MEM_SIZE);
  localparam logic [4:0] LANE_MAX = 5'(LANES);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STORE,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [IW-1:0]               idx_q;
  logic [ADDRESS_WIDTH-1:0]    addr_q;
  logic [ADDRESS_WIDTH-1:0]    stride_q;
  logic [3:0]                  cnt_q;
  logic [LANES*DATA_WIDTH-1:0] store_q;
  logic [LANES*DATA_WIDTH-1:0] load_q;
  logic                        error_q;

  logic accept;
  logic bad_count;
  logic zero_count;
  logic active;
  logic in_bounds;
  logic last;

  assign accept     = (state_q == IDLE) && start;
  assign bad_count  = {1'b0, count} > LANE_MAX;
  assign zero_count = (count == 4'd0);
  assign active     = (state_q == LOAD) || (state_q == STORE);
  assign in_bounds  = {1'b0, addr_q} < MEM_LIMIT;
  assign last       = (5'(idx_q) + 5'd1) == {1'b0, cnt_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (bad_count || zero_count) begin
            state_d = DONE;
          end else if (isStore) begin
            state_d = STORE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD, STORE: begin
        if (!in_bounds || last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operands only change on an accepted start; loadData only on load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q    <= '0;
      addr_q   <= '0;
      stride_q <= '0;
      cnt_q    <= '0;
      store_q  <= '0;
      load_q   <= '0;
      error_q  <= 1'b0;
    end else if (accept) begin
      idx_q    <= '0;
      addr_q   <= baseAddress;
      stride_q <= stride;
      cnt_q    <= count;
      store_q  <= storeData;
      error_q  <= bad_count;
      if (!isStore && !bad_count && !zero_count) begin
        load_q <= '0;
      end
    end else if (active) begin
      if (!in_bounds) begin
        error_q <= 1'b1;
      end else begin
        if (state_q == LOAD) begin
          load_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] <= memReadData;
        end
        idx_q  <= idx_q + IW'(1);
        addr_q <= addr_q + stride_q;
      end
    end
  end

  logic rd_go;
  logic wr_go;

  assign rd_go = (state_q == LOAD) && in_bounds;
  assign wr_go = (state_q == STORE) && in_bounds;

  assign memReadAddress  = rd_go ? addr_q : '0;
  assign memWriteEnable  = wr_go;
  assign memWriteAddress = wr_go ? addr_q : '0;
  assign memWriteData    = wr_go
    ? store_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH]
    : '0;

  assign loadData = load_q;
  assign busy     = active;
  assign done     = (state_q == DONE);
  assign error    = error_q;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed bench for vector_mem_sequencer with a behavioural memory
// and a queue of expected transfer outcomes.
module tb_vector_mem_sequencer;

  localparam int AW = 19;
  localparam int DW = 64;
  localparam int LN = 8;
  localparam int VW = LN*DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          isStore;
  logic [AW-1:0] baseAddress;
  logic [AW-1:0] stride;
  logic [3:0]    count;
  logic [VW-1:0] storeData;
  logic [DW-1:0] memReadData;
  logic [AW-1:0] memReadAddress;
  logic [AW-1:0] memWriteAddress;
  logic [DW-1:0] memWriteData;
  logic          memWriteEnable;
  logic [VW-1:0] loadData;
  logic          busy;
  logic          done;
  logic          error;

  vector_mem_sequencer #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LANES(LN),
    .MEM_SIZE(2000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .isStore(isStore),
    .baseAddress(baseAddress),
    .stride(stride),
    .count(count),
    .storeData(storeData),
    .memReadData(memReadData),
    .memReadAddress(memReadAddress),
    .memWriteAddress(memWriteAddress),
    .memWriteData(memWriteData),
    .memWriteEnable(memWriteEnable),
    .loadData(loadData),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:1999];
  logic          pre_we = 1'b0;
  int            pre_addr = 0;
  logic [DW-1:0] pre_data = '0;
  int            wr_cnt = 0;
  int            done_cnt = 0;

  always_comb begin
    memReadData = '0;
    if (int'(memReadAddress) < 2000) memReadData = mem[int'(memReadAddress)];
  end

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (memWriteEnable) begin
      if (int'(memWriteAddress) < 2000) mem[int'(memWriteAddress)] <= memWriteData;
      wr_cnt <= wr_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  typedef struct {
    logic          err;
    int            lat;
    logic [VW-1:0] ld;
    bit            chk_ld;
    int            wr;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [VW-1:0] obs,
                       input logic [VW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic st,
                        input logic [AW-1:0] base, input logic [AW-1:0] strd,
                        input logic [3:0] cnt, input logic [VW-1:0] sd,
                        input exp_t e, input bit poke);
    exp_t got;
    int lat;
    int w0;
    int d0;
    sb.push_back(e);
    @(negedge clk);
    w0 = wr_cnt; d0 = done_cnt;
    start = 1'b1; isStore = st; baseAddress = base;
    stride = strd; count = cnt; storeData = sd;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 30) begin
      if (poke && lat == 3) begin
        start = 1'b1; isStore = 1'b1; count = 4'd1;
        baseAddress = 19'd500; stride = 19'd1;
      end
      if (poke && lat == 5) start = 1'b0;
      @(negedge clk);
      lat++;
    end
    got = sb.pop_front();
    check({tag, "_done"}, VW'(done), VW'(1));
    check({tag, "_latency"}, VW'(lat), VW'(got.lat));
    check({tag, "_error"}, VW'(error), VW'(got.err));
    if (got.chk_ld) check({tag, "_loadData"}, loadData, got.ld);
    check({tag, "_writes"}, VW'(wr_cnt - w0), VW'(got.wr));
    @(negedge clk);
    check({tag, "_done_pulse"}, VW'(done), VW'(0));
    check({tag, "_error_hold"}, VW'(error), VW'(got.err));
    check({tag, "_done_count"}, VW'(done_cnt - d0), VW'(1));
  endtask

  localparam logic [DW-1:0] VA = 64'hAAAA_0000_0000_0001;
  localparam logic [DW-1:0] VB = 64'hBBBB_0000_0000_0002;
  localparam logic [DW-1:0] VC = 64'hCCCC_0000_0000_0003;
  localparam logic [DW-1:0] VD = 64'hDDDD_0000_0000_0004;
  localparam logic [DW-1:0] VI = 64'h1111_2222_3333_4444;

  initial begin
    exp_t e;
    logic [VW-1:0] v;
    logic [VW-1:0] last_ld;
    int w0;
    int d0;
    reset = 1'b0; start = 1'b0; isStore = 1'b0;
    baseAddress = '0; stride = '0; count = '0; storeData = '0;
    #2;
    check("rst_busy", VW'(busy), VW'(0));
    check("rst_done", VW'(done), VW'(0));
    check("rst_error", VW'(error), VW'(0));
    check("rst_we", VW'(memWriteEnable), VW'(0));
    check("rst_raddr", VW'(memReadAddress), VW'(0));
    check("rst_wdata", VW'(memWriteData), VW'(0));
    check("rst_loadData", loadData, VW'(0));
    @(negedge clk);
    reset = 1'b1;

    preload(10, VA); preload(12, VB); preload(14, VC); preload(16, VD);
    preload(8, VI);
    for (int i = 0; i < 4; i++) preload(18 + 2*i, 64'h5000 + DW'(i));

    // strided load, upper lanes zero
    v = '0;
    v[0*DW +: DW] = VA; v[1*DW +: DW] = VB;
    v[2*DW +: DW] = VC; v[3*DW +: DW] = VD;
    e = '{err: 1'b0, lat: 5, ld: v, chk_ld: 1'b1, wr: 0};
    run_op("load4", 1'b0, 19'd10, 19'd2, 4'd4, '1, e, 1'b0);
    last_ld = v;

    // unit-stride store of lane i = i+1
    v = '0;
    for (int i = 0; i < LN; i++) v[i*DW +: DW] = DW'(i + 1);
    e = '{err: 1'b0, lat: 9, ld: last_ld, chk_ld: 1'b1, wr: 8};
    run_op("store8", 1'b1, 19'd100, 19'd1, 4'd8, v, e, 1'b0);
    for (int i = 0; i < LN; i++)
      check($sformatf("store8_mem%0d", 100 + i), VW'(mem[100 + i]),
            VW'(i + 1));

    // store running off the end of memory
    v = '0;
    for (int i = 0; i < LN; i++) v[i*DW +: DW] = DW'(64'h50 + i);
    e = '{err: 1'b1, lat: 4, ld: last_ld, chk_ld: 1'b1, wr: 2};
    run_op("store_oob", 1'b1, 19'd1998, 19'd1, 4'd4, v, e, 1'b0);
    check("store_oob_m1998", VW'(mem[1998]), VW'(64'h50));
    check("store_oob_m1999", VW'(mem[1999]), VW'(64'h51));

    // aborted load keeps captured lanes
    v = '0;
    v[0*DW +: DW] = 64'h50; v[1*DW +: DW] = 64'h51;
    e = '{err: 1'b1, lat: 4, ld: v, chk_ld: 1'b1, wr: 0};
    run_op("load_oob", 1'b0, 19'd1998, 19'd1, 4'd4, '0, e, 1'b0);

    // negative stride via modular wrap: 12, 10, 8
    v = '0;
    v[0*DW +: DW] = VB; v[1*DW +: DW] = VA; v[2*DW +: DW] = VI;
    e = '{err: 1'b0, lat: 4, ld: v, chk_ld: 1'b1, wr: 0};
    run_op("load_wrap", 1'b0, 19'd12, 19'h7FFFE, 4'd3, '0, e, 1'b0);
    last_ld = v;

    e = '{err: 1'b1, lat: 1, ld: last_ld, chk_ld: 1'b1, wr: 0};
    run_op("count9", 1'b1, 19'd100, 19'd1, 4'd9, '0, e, 1'b0);
    e = '{err: 1'b0, lat: 1, ld: last_ld, chk_ld: 1'b1, wr: 0};
    run_op("count0", 1'b1, 19'd100, 19'd1, 4'd0, '0, e, 1'b0);

    // start pulsed while busy must be ignored
    v = '0;
    v[0*DW +: DW] = VA; v[1*DW +: DW] = VB;
    v[2*DW +: DW] = VC; v[3*DW +: DW] = VD;
    for (int i = 0; i < 4; i++) v[(4+i)*DW +: DW] = 64'h5000 + DW'(i);
    e = '{err: 1'b0, lat: 9, ld: v, chk_ld: 1'b1, wr: 0};
    run_op("busy_start", 1'b0, 19'd10, 19'd2, 4'd8, '0, e, 1'b1);
    repeat (3) @(negedge clk);
    check("busy_start_idle", VW'(busy), VW'(0));

    // reset after three of eight writes
    v = '0;
    for (int i = 0; i < LN; i++) v[i*DW +: DW] = DW'(64'h70 + i);
    @(negedge clk);
    w0 = wr_cnt; d0 = done_cnt;
    start = 1'b1; isStore = 1'b1; baseAddress = 19'd200;
    stride = 19'd1; count = 4'd8; storeData = v;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_we", VW'(memWriteEnable), VW'(0));
    check("rst_mid_busy", VW'(busy), VW'(0));
    repeat (3) @(negedge clk);
    check("rst_mid_writes", VW'(wr_cnt - w0), VW'(3));
    check("rst_mid_nodone", VW'(done_cnt - d0), VW'(0));
    check("rst_mid_m202", VW'(mem[202]), VW'(64'h72));
    check("rst_mid_loadData", loadData, VW'(0));
    reset = 1'b1;

    v = '0;
    v[0*DW +: DW] = VA; v[1*DW +: DW] = VB;
    e = '{err: 1'b0, lat: 3, ld: v, chk_ld: 1'b1, wr: 0};
    run_op("after_rst", 1'b0, 19'd10, 19'd2, 4'd2, '0, e, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vector_mem_sequencer.md
VECTOR_MEM_SEQUENCER -- requirements
Module: vector_mem_sequencer

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 19, memory word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, width of one memory word / vector element.
REQ-003 SHALL have parameter LANES, default 8, maximum elements per vector transfer.
REQ-004 SHALL have parameter MEM_SIZE, default 2000, number of valid memory words (legal addresses 0..MEM_SIZE-1).
REQ-005 SHALL have port clk  input  1  rising-edge clock; one clock, shared with the memory block.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  request to begin a transfer; sampled only in IDLE.
REQ-008 SHALL have port isStore  input  1  1 = vector store, 0 = vector load; sampled with start.
REQ-009 SHALL have port baseAddress  input  ADDRESS_WIDTH  address of element 0.
REQ-010 SHALL have port stride  input  ADDRESS_WIDTH  unsigned address increment between elements.
REQ-011 SHALL have port count  input  4  number of elements to transfer; legal values 0..LANES.
REQ-012 SHALL have port storeData  input  LANES*DATA_WIDTH  store vector; element i at bits [64i+63:64i].
REQ-013 SHALL have port memReadData  input  DATA_WIDTH  combinational read data returned by memory for memReadAddress.
REQ-014 SHALL have port memReadAddress  output  ADDRESS_WIDTH  memory read address.
REQ-015 SHALL have port memWriteAddress  output  ADDRESS_WIDTH  memory write address.
REQ-016 SHALL have port memWriteData  output  DATA_WIDTH  memory write data.
REQ-017 SHALL have port memWriteEnable  output  1  memory write strobe; memory writes on the rising clk edge.
REQ-018 SHALL have port loadData  output  LANES*DATA_WIDTH  gathered load vector, same lane layout as storeData.
REQ-019 SHALL have port busy  output  1  high while in LOAD or STORE.
REQ-020 SHALL have port done  output  1  single-cycle completion pulse.
REQ-021 SHALL have port error  output  1  transfer was rejected or aborted; valid while done=1.

Function
REQ-022 SHALL implement the FSM states IDLE, LOAD, STORE and DONE; DONE always returns to IDLE on the next cycle.
REQ-023 In IDLE with start=1, SHALL latch isStore, baseAddress, stride, count and storeData, set element index idx=0 and current address addr=baseAddress.
REQ-024 In the same IDLE/start cycle, SHALL go to DONE with error=1 and no memory access if count>LANES.
REQ-025 In the same IDLE/start cycle, SHALL go to DONE with error=0 and no memory access if count=0.
REQ-026 Otherwise, in the same IDLE/start cycle, SHALL go to LOAD or STORE according to isStore.
REQ-027 On a load start, SHALL clear every loadData lane to 0.
REQ-028 SHALL ignore start while busy=1 or while in DONE; latched operands SHALL remain unchanged.
REQ-029 SHALL perform exactly one memory access per cycle in LOAD/STORE, at addr, for element idx.
REQ-030 SHALL update addr as addr+stride modulo 2^ADDRESS_WIDTH after each element; wrap-around itself is legal.
REQ-031 SHALL perform the bounds check before each access: if addr>=MEM_SIZE, issue no access for that element, set error=1 and go to DONE.
REQ-032 In LOAD, SHALL drive memReadAddress=addr and capture memReadData into lane idx of loadData at the rising edge.
REQ-033 In STORE, SHALL drive memWriteEnable=1, memWriteAddress=addr and memWriteData=latched lane idx.
REQ-034 Outside STORE, memWriteEnable SHALL be 0.
REQ-035 In LOAD/STORE, after element idx=count-1, SHALL go to DONE with error=0.
REQ-036 Latency SHALL be count+1 cycles from the start-sampling edge to the done pulse for a legal, in-bounds transfer.
REQ-037 done SHALL be 1 only in DONE; error SHALL hold its value until the next accepted start.
REQ-038 loadData SHALL hold its value after DONE until the next load start; a store SHALL NOT modify loadData.
REQ-039 On an aborted load, SHALL keep the lanes already captured and leave the remaining lanes at 0.

Reset
REQ-040 When reset=0, SHALL asynchronously force: state IDLE, idx=0, addr=0, busy=0, done=0, error=0, memWriteEnable=0, memReadAddress=0, memWriteAddress=0, memWriteData=0, loadData=0.
REQ-041 Reset during LOAD/STORE SHALL abort the transfer with no further writes and no done pulse.
REQ-042 The first start SHALL be accepted on the first rising edge with reset=1.

Verification
REQ-043 Load: memory words 10,12,14,16 preloaded with A,B,C,D; load base=10 stride=2 count=4 -> reads 10,12,14,16; loadData lanes0-3=A,B,C,D, lanes4-7=0; done at cycle 5, error=0.
REQ-044 Store: store base=100 stride=1 count=8 with lane i=i+1 -> memWriteEnable high for 8 cycles; memory words 100..107 = 1..8; done at cycle 9.
REQ-045 Bounds: store base=1998 stride=1 count=4 -> writes to 1998 and 1999 only; third cycle memWriteEnable=0; done=1 with error=1.
REQ-046 Rejected start: count=9 -> done the next cycle with error=1 and no access; count=0 -> done the next cycle with error=0.
REQ-047 Start while busy: second start during a count=8 load is ignored; exactly one done pulse occurs.
REQ-048 Reset mid-store: reset asserted after 3 of 8 writes -> memWriteEnable=0 immediately; only 3 words written; no done; next start works normally.
